// File: rtl/move_validator.sv
// ---------------------------------------------------------------------------
// MoveValidator (module move_validator)
//
// Decides whether a single chess move is legal by reading the board through
// an external memory port. The board is addressed one square at a time via
// validate_x/validate_y; the piece code comes back on validate_square after
// READ_LATENCY cycles.
//
// Piece codes: 0 empty, 1-6 black P/N/B/R/Q/K, 7-12 white P/N/B/R/Q/K.
//
// Ports:
//   clk              system clock, rising edge only
//   reset            synchronous, active-low
//   start            one-cycle request; ignored while a validation runs
//   piece_x/piece_y  source square (0..7 legal, anything else is rejected)
//   move_x/move_y    destination square (0..7 legal)
//   validate_square  piece code read back from board memory
//   validate_x/_y    square currently addressed in board memory
//   busy             high while a validation is in progress
//   done             one-cycle pulse when legal carries the verdict
//   legal            verdict, held until the next accepted start
//
// Flow: IDLE -> RD_SRC -> RD_DST -> GEOM -> SCAN -> FINISH -> IDLE, with
// early exits to FINISH for bad coordinates, an empty source, a friendly
// piece on the destination, bad geometry, or a blocked path.
// Check/checkmate, castling, en passant and promotion are not handled.
// ---------------------------------------------------------------------------
module move_validator #(
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] piece_x,
  input  logic [3:0] piece_y,
  input  logic [3:0] move_x,
  input  logic [3:0] move_y,
  input  logic [3:0] validate_square,
  output logic [3:0] validate_x,
  output logic [3:0] validate_y,
  output logic       busy,
  output logic       done,
  output logic       legal
);

  typedef enum logic [2:0] {
    IDLE,
    RD_SRC,
    RD_DST,
    GEOM,
    SCAN,
    FINISH
  } state_t;

  // Wait counter value on which the addressed square's data is valid.
  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  state_t     state, state_n;

  logic [3:0] src_x, src_y, dst_x, dst_y;
  logic [3:0] src_x_n, src_y_n, dst_x_n, dst_y_n;
  logic [3:0] src_code, dst_code, src_code_n, dst_code_n;
  logic [3:0] addr_x_n, addr_y_n;
  logic [1:0] wait_cnt, wait_cnt_n;
  logic [3:0] step_x, step_y, step_x_n, step_y_n;
  logic       scan_rd, scan_rd_n;
  logic       scan_skip, scan_skip_n;
  logic       legal_n;

  // Geometry and colour helpers, all derived from latched registers.
  logic [4:0] dx, dy, adx, ady;
  logic       src_white, vs_white, same_colour;
  logic [3:0] src_type;
  logic       fwd_one, fwd_two, on_start_rank;
  logic       geom_ok, need_scan;
  logic [3:0] calc_step_x, calc_step_y;

  // Scan cursor: the first step starts from the source square, later steps
  // from whatever square is currently addressed.
  logic [3:0] next_x, next_y;
  logic       next_is_dst;

  logic       read_last;
  logic       coords_bad;

  // Geometry evaluation. dx/dy are 5-bit two's complement, so -1 is 5'h1F
  // and -2 is 5'h1E. Pawn direction depends on colour: black moves +y,
  // white moves -y. Sliding pieces (and the pawn double step) need the
  // intermediate squares scanned; knights, kings and single pawn steps
  // never do.
  always_comb begin
    dx            = {1'b0, dst_x} - {1'b0, src_x};
    dy            = {1'b0, dst_y} - {1'b0, src_y};
    adx           = dx[4] ? (5'd0 - dx) : dx;
    ady           = dy[4] ? (5'd0 - dy) : dy;
    src_white     = (src_code >= 4'd7);
    src_type      = src_white ? (src_code - 4'd6) : src_code;
    fwd_one       = src_white ? (dy == 5'h1F) : (dy == 5'd1);
    fwd_two       = src_white ? (dy == 5'h1E) : (dy == 5'd2);
    on_start_rank = src_white ? (src_y == 4'd6) : (src_y == 4'd1);
    calc_step_x   = (dx == 5'd0) ? 4'd0 : (dx[4] ? 4'hF : 4'd1);
    calc_step_y   = (dy == 5'd0) ? 4'd0 : (dy[4] ? 4'hF : 4'd1);

    geom_ok   = 1'b0;
    need_scan = 1'b0;
    case (src_type)
      4'd1: begin
        if (dx == 5'd0 && fwd_one && dst_code == 4'd0) begin
          geom_ok = 1'b1;
        end else if (dx == 5'd0 && fwd_two && on_start_rank && dst_code == 4'd0) begin
          geom_ok   = 1'b1;
          need_scan = 1'b1;
        end else if (adx == 5'd1 && fwd_one && dst_code != 4'd0) begin
          // Friendly pieces were already rejected, so this is a capture.
          geom_ok = 1'b1;
        end
      end
      4'd2: begin
        geom_ok = (adx == 5'd1 && ady == 5'd2) || (adx == 5'd2 && ady == 5'd1);
      end
      4'd3: begin
        geom_ok   = (adx == ady);
        need_scan = 1'b1;
      end
      4'd4: begin
        geom_ok   = (dx == 5'd0) || (dy == 5'd0);
        need_scan = 1'b1;
      end
      4'd5: begin
        geom_ok   = (dx == 5'd0) || (dy == 5'd0) || (adx == ady);
        need_scan = 1'b1;
      end
      4'd6: begin
        // Source and destination differ, so at least one of adx/ady is 1.
        geom_ok = (adx <= 5'd1) && (ady <= 5'd1);
      end
      default: begin
        geom_ok = 1'b0;
      end
    endcase
  end

  // Helpers shared by the read and scan states.
  always_comb begin
    vs_white    = (validate_square >= 4'd7);
    same_colour = (vs_white == src_white);
    read_last   = (wait_cnt == LAST_WAIT);
    coords_bad  = piece_x[3] | piece_y[3] | move_x[3] | move_y[3];
    next_x      = (scan_rd ? validate_x : src_x) + step_x;
    next_y      = (scan_rd ? validate_y : src_y) + step_y;
    next_is_dst = (next_x == dst_x) && (next_y == dst_y);
  end

  // Next-state and datapath logic. Every register holds by default; legal
  // is cleared on acceptance and only ever set on the transition into
  // FINISH, so it reads 0 throughout a validation.
  always_comb begin
    state_n     = state;
    src_x_n     = src_x;
    src_y_n     = src_y;
    dst_x_n     = dst_x;
    dst_y_n     = dst_y;
    src_code_n  = src_code;
    dst_code_n  = dst_code;
    addr_x_n    = validate_x;
    addr_y_n    = validate_y;
    wait_cnt_n  = wait_cnt;
    step_x_n    = step_x;
    step_y_n    = step_y;
    scan_rd_n   = scan_rd;
    scan_skip_n = scan_skip;
    legal_n     = legal;
    busy        = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          src_x_n    = piece_x;
          src_y_n    = piece_y;
          dst_x_n    = move_x;
          dst_y_n    = move_y;
          legal_n    = 1'b0;
          wait_cnt_n = 2'd0;
          if (coords_bad || (piece_x == move_x && piece_y == move_y)) begin
            // Rejected without touching the memory address.
            state_n = FINISH;
          end else begin
            addr_x_n = piece_x;
            addr_y_n = piece_y;
            state_n  = RD_SRC;
          end
        end
      end

      RD_SRC: begin
        busy = 1'b1;
        if (read_last) begin
          src_code_n = validate_square;
          if (validate_square == 4'd0 || validate_square > 4'd12) begin
            state_n = FINISH;
          end else begin
            addr_x_n   = dst_x;
            addr_y_n   = dst_y;
            wait_cnt_n = 2'd0;
            state_n    = RD_DST;
          end
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end

      RD_DST: begin
        busy = 1'b1;
        if (read_last) begin
          dst_code_n = validate_square;
          if (validate_square > 4'd12 ||
              (validate_square != 4'd0 && same_colour)) begin
            state_n = FINISH;
          end else begin
            state_n = GEOM;
          end
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end

      GEOM: begin
        busy        = 1'b1;
        step_x_n    = calc_step_x;
        step_y_n    = calc_step_y;
        scan_rd_n   = 1'b0;
        scan_skip_n = ~need_scan;
        state_n     = geom_ok ? SCAN : FINISH;
      end

      // SCAN spends one cycle taking the first step, then READ_LATENCY
      // cycles per intermediate square. Reaching the destination means the
      // path is clear; it is never read here.
      SCAN: begin
        busy = 1'b1;
        if (!scan_rd) begin
          if (scan_skip || next_is_dst) begin
            legal_n = 1'b1;
            state_n = FINISH;
          end else begin
            addr_x_n   = next_x;
            addr_y_n   = next_y;
            scan_rd_n  = 1'b1;
            wait_cnt_n = 2'd0;
          end
        end else if (read_last) begin
          if (validate_square != 4'd0) begin
            state_n = FINISH;
          end else if (next_is_dst) begin
            legal_n = 1'b1;
            state_n = FINISH;
          end else begin
            addr_x_n   = next_x;
            addr_y_n   = next_y;
            wait_cnt_n = 2'd0;
          end
        end else begin
          wait_cnt_n = wait_cnt + 2'd1;
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any validation in flight
  // and also masks a start arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      src_x      <= 4'd0;
      src_y      <= 4'd0;
      dst_x      <= 4'd0;
      dst_y      <= 4'd0;
      src_code   <= 4'd0;
      dst_code   <= 4'd0;
      validate_x <= 4'd0;
      validate_y <= 4'd0;
      wait_cnt   <= 2'd0;
      step_x     <= 4'd0;
      step_y     <= 4'd0;
      scan_rd    <= 1'b0;
      scan_skip  <= 1'b0;
      legal      <= 1'b0;
    end else begin
      state      <= state_n;
      src_x      <= src_x_n;
      src_y      <= src_y_n;
      dst_x      <= dst_x_n;
      dst_y      <= dst_y_n;
      src_code   <= src_code_n;
      dst_code   <= dst_code_n;
      validate_x <= addr_x_n;
      validate_y <= addr_y_n;
      wait_cnt   <= wait_cnt_n;
      step_x     <= step_x_n;
      step_y     <= step_y_n;
      scan_rd    <= scan_rd_n;
      scan_skip  <= scan_skip_n;
      legal      <= legal_n;
    end
  end

endmodule

// File: doc/move_validator.md
MOVE_VALIDATOR -- requirements
Module: move_validator

Interface
REQ-001 Parameter READ_LATENCY, default 1, SHALL be the cycles from validate_x/validate_y change to valid validate_square data; legal values 1 or 2.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start  input  1  one-cycle request pulse to validate a move.
REQ-005 piece_x, piece_y  input  4 each  source square; valid range 0..7.
REQ-006 move_x, move_y  input  4 each  destination square; valid range 0..7.
REQ-007 validate_square  input  4  piece code read from board memory (0 empty, 1-6 black P/N/B/R/Q/K, 7-12 white P/N/B/R/Q/K).
REQ-008 validate_x, validate_y  output  4 each  square currently addressed in board memory.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle pulse when result is valid.
REQ-011 legal  output  1  verdict; held from done until next accepted start.

Function
REQ-012 FSM states SHALL be IDLE, RD_SRC, RD_DST, GEOM, SCAN, FINISH.
REQ-013 In IDLE, start=1 SHALL latch all four coordinates, set busy, clear legal, and enter RD_SRC; start while busy SHALL be ignored.
REQ-014 Any coordinate >7, or source equal to destination, SHALL go directly to FINISH with legal=0, issuing no reads.
REQ-015 RD_SRC SHALL drive source address, wait READ_LATENCY cycles, latch source code; code 0 SHALL give legal=0.
REQ-016 RD_DST SHALL drive destination address, wait READ_LATENCY cycles, latch destination code; same-colour destination SHALL give legal=0.
REQ-017 GEOM SHALL evaluate geometry in one cycle using signed dx=move_x-piece_x, dy=move_y-piece_y (5-bit two's complement).
REQ-018 Knight: legal iff {|dx|,|dy|} = {1,2}.
REQ-019 King: legal iff max(|dx|,|dy|)=1; castling not supported.
REQ-020 Rook: dx=0 or dy=0; Bishop: |dx|=|dy|; Queen: either; these SHALL proceed to SCAN.
REQ-021 Black pawns advance +y, white pawns -y: one step forward to empty square; two steps from start rank (black y=1, white y=6) to empty square with intermediate square scanned; diagonal forward step only onto opposite-colour piece; en passant and promotion not supported.
REQ-022 SCAN SHALL step from source toward destination by (sign dx, sign dy), reading each intermediate square excluding both endpoints; any non-zero code SHALL give legal=0 and end scan immediately.
REQ-023 SCAN with zero intermediate squares SHALL take no read cycles.
REQ-024 FINISH SHALL assert done for exactly one cycle, drop busy the same cycle, and return to IDLE.
REQ-025 Check and checkmate detection are out of scope.
REQ-026 validate_x/validate_y SHALL hold their last value in IDLE.
REQ-027 Total latency start-to-done SHALL be 3+2*READ_LATENCY+k*READ_LATENCY cycles, k = intermediate squares read; early-reject paths SHALL be shorter.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, busy=0, done=0, legal=0, validate_x=0, validate_y=0, abandoning any in-progress validation without a done pulse.
REQ-029 start coincident with reset=0 SHALL be ignored.

Verification
REQ-030 Standard opening board, start with piece (1,0) to (2,2) black knight -> done pulse, legal=1, 5 cycles at READ_LATENCY=1.
REQ-031 Standard board, black rook (0,0) to (0,3) -> scan hits black pawn at (0,1), legal=0.
REQ-032 Board with white pawn (4,6), empty (4,5),(4,4): move to (4,4) -> legal=1; move to (4,3) -> legal=0.
REQ-033 White bishop (2,7) to (5,4) with empty path and black pawn at (5,4) -> legal=1; same with (4,5) occupied -> legal=0.
REQ-034 piece=(8,0) or source=destination -> done within 2 cycles, legal=0, no address change.
REQ-035 Assert reset=0 mid-SCAN -> next cycle busy=0, done never pulses; repeat one scenario at READ_LATENCY=2 -> same verdicts.
